// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, one operation in flight; the result and carry are
// registered and returned on a single response channel tagged with the id.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req{0,1}_valid/ready        request handshake (ready is combinational)
//   req{0,1}_a/_b/_sel          request operands and opcode
//   alu_a/alu_b/alu_sel         registered drive to the external ALU
//   alu_out/alu_carry           ALU result inputs
//   rsp_valid/ready/id/data/carry/err  response channel
module alu_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned NUM_OPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err
);

  // One extra bit so NUM_OPS == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] OP_LIMIT = (SEL_W+1)'(NUM_OPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic             r_cur_id;
  logic             r_illegal;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_carry;
  logic             r_rsp_err;

  logic             w_any;
  logic             w_pick_id;
  logic             w_accept;
  logic             w_illegal;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [SEL_W-1:0] w_sel_op;

  // Round-robin winner selection and operand mux; reset suppresses ready.
  always_comb begin
    w_any     = req0_valid | req1_valid;
    w_pick_id = 1'b0;
    if (req0_valid && req1_valid) begin
      w_pick_id = ~r_last_grant;
    end else if (req1_valid) begin
      w_pick_id = 1'b1;
    end
    w_accept  = rst_n && (r_state == S_IDLE) && w_any;
    w_sel_a   = w_pick_id ? req1_a   : req0_a;
    w_sel_b   = w_pick_id ? req1_b   : req0_b;
    w_sel_op  = w_pick_id ? req1_sel : req0_sel;
    w_illegal = ({1'b0, w_sel_op} >= OP_LIMIT);
  end

  assign req0_ready = w_accept & ~w_pick_id;
  assign req1_ready = w_accept &  w_pick_id;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cur_id     <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cur_id     <= w_pick_id;
            r_last_grant <= w_pick_id;
            r_illegal    <= w_illegal;
            // ALU inputs are loaded for the EXEC cycle only; illegal ops leave them 0.
            if (!w_illegal) begin
              r_alu_a   <= w_sel_a;
              r_alu_b   <= w_sel_b;
              r_alu_sel <= w_sel_op;
            end
          end
        end
        S_EXEC: begin
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_sel   <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_cur_id;
          r_rsp_data  <= r_illegal ? '0 : alu_out;
          r_rsp_carry <= r_illegal ? 1'b0 : alu_carry;
          r_rsp_err   <= r_illegal;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_err   = r_rsp_err;

endmodule
